// File: rtl/clkgate_seq.sv
// clkgate_seq: enable sequencer for a two-stage clock-gating block.
// Turns level requests into ordered gate-enable steps (sw0 before sw1 on the
// way up, sw1 before sw0 on the way down), holds every enable change for
// SETTLE cycles, and keeps each stable level for at least MINON cycles.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   req_vld  level request valid
//   req_lvl  requested level (0 gated, 1 stage0, 2/3 both stages)
//   req_rdy  request accepted when req_vld & req_rdy at a rising edge
//   ack      one-cycle pulse when the requested level is reached
//   busy     high in any transition state
//   cur_lvl  currently settled level (0/1/2)
//   sw0      stage-0 gate enable (registered)
//   sw1      stage-1 gate enable (registered)
module clkgate_seq #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned MINON  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_vld,
  input  logic [1:0] req_lvl,
  output logic       req_rdy,
  output logic       ack,
  output logic       busy,
  output logic [1:0] cur_lvl,
  output logic       sw0,
  output logic       sw1
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] MINON_CNT   = CW'(MINON);
  localparam logic [CW-1:0] CNT_SAT     = '1;

  typedef enum logic [2:0] {
    ST_L0  = 3'd0,
    ST_L1  = 3'd1,
    ST_L2  = 3'd2,
    ST_UP0 = 3'd3,
    ST_UP1 = 3'd4,
    ST_DN1 = 3'd5,
    ST_DN0 = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [1:0]    cur_lvl_q, cur_lvl_d;
  logic          sw0_q, sw0_d;
  logic          sw1_q, sw1_d;

  logic          stable_q;
  logic          accept;
  logic          same_acc;
  logic [1:0]    req_lvl_sat;

  // Stable-level flag and request handshake, derived only from registers.
  assign stable_q    = (state_q == ST_L0) || (state_q == ST_L1) || (state_q == ST_L2);
  assign req_rdy     = stable_q && (dwell_q >= MINON_CNT);
  assign accept      = req_vld && req_rdy;
  assign req_lvl_sat = (req_lvl == 2'd3) ? 2'd2 : req_lvl;

  // State register and datapath/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_L0;
      tgt_q     <= 2'd0;
      settle_q  <= '0;
      dwell_q   <= CNT_SAT;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      cur_lvl_q <= 2'd0;
      sw0_q     <= 1'b0;
      sw1_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      settle_q  <= settle_d;
      dwell_q   <= dwell_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      cur_lvl_q <= cur_lvl_d;
      sw0_q     <= sw0_d;
      sw1_q     <= sw1_d;
    end
  end

  // Next-state logic: request acceptance and settle-interval sequencing.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    dwell_d  = (dwell_q == CNT_SAT) ? CNT_SAT : dwell_q + CW'(1);
    same_acc = 1'b0;

    if (stable_q) begin
      if (accept) begin
        tgt_d    = req_lvl_sat;
        settle_d = '0;
        if (req_lvl_sat == cur_lvl_q) begin
          // Same level: ack only, dwell keeps counting.
          same_acc = 1'b1;
        end else if (req_lvl_sat > cur_lvl_q) begin
          state_d = (state_q == ST_L0) ? ST_UP0 : ST_UP1;
        end else begin
          state_d = (state_q == ST_L2) ? ST_DN1 : ST_DN0;
        end
      end
    end else begin
      // Dwell held at zero so it starts from zero on stable-state entry.
      dwell_d = '0;
      if (settle_q == SETTLE_LAST) begin
        settle_d = '0;
        case (state_q)
          ST_UP0:  state_d = (tgt_q == 2'd2) ? ST_UP1 : ST_L1;
          ST_UP1:  state_d = ST_L2;
          ST_DN1:  state_d = (tgt_q == 2'd0) ? ST_DN0 : ST_L1;
          ST_DN0:  state_d = ST_L0;
          default: state_d = ST_L0;
        endcase
      end else begin
        settle_d = settle_q + CW'(1);
      end
    end
  end

  // Output logic: next values of the registered outputs from the next state.
  always_comb begin
    sw0_d     = 1'b0;
    sw1_d     = 1'b0;
    busy_d    = 1'b0;
    cur_lvl_d = cur_lvl_q;
    ack_d     = same_acc;
    case (state_d)
      ST_L0: begin
        cur_lvl_d = 2'd0;
        ack_d     = same_acc || busy_q;
      end
      ST_L1: begin
        sw0_d     = 1'b1;
        cur_lvl_d = 2'd1;
        ack_d     = same_acc || busy_q;
      end
      ST_L2: begin
        sw0_d     = 1'b1;
        sw1_d     = 1'b1;
        cur_lvl_d = 2'd2;
        ack_d     = same_acc || busy_q;
      end
      ST_UP0: begin
        sw0_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_UP1: begin
        sw0_d  = 1'b1;
        sw1_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_DN1: begin
        sw0_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_DN0: begin
        busy_d = 1'b1;
      end
      default: begin
        cur_lvl_d = 2'd0;
      end
    endcase
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign cur_lvl = cur_lvl_q;
  assign sw0     = sw0_q;
  assign sw1     = sw1_q;

endmodule

// File: tb/tb_clkgate_seq.sv
// Testbench for clkgate_seq: cycle-by-cycle vector table for the basic level
// changes, hand sequences for dwell/hold, same-level and mid-transition reset.
module tb_clkgate_seq;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned MINON  = 2;

  logic       clk;
  logic       rst;
  logic       req_vld;
  logic [1:0] req_lvl;
  logic       req_rdy;
  logic       ack;
  logic       busy;
  logic [1:0] cur_lvl;
  logic       sw0;
  logic       sw1;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;
  int exp_acks = 0;

  clkgate_seq #(.SETTLE(SETTLE), .MINON(MINON)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_lvl (req_lvl),
    .req_rdy (req_rdy),
    .ack     (ack),
    .busy    (busy),
    .cur_lvl (cur_lvl),
    .sw0     (sw0),
    .sw1     (sw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] lvl;
    logic       rdy;
    logic       ack;
    logic       busy;
    logic [1:0] cur;
    logic       sw0;
    logic       sw1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [1:0] l,
                     input logic rdy, input logic a, input logic b,
                     input logic [1:0] c, input logic s0, input logic s1,
                     input int n);
    vec_t e;
    e = '{rst: r, vld: v, lvl: l, rdy: rdy, ack: a, busy: b, cur: c, sw0: s0, sw1: s1};
    repeat (n) vecs.push_back(e);
  endtask

  // Inputs driven at a falling edge; outputs sampled at the next falling edge.
  task automatic step(input logic r, input logic v, input logic [1:0] l);
    rst     = r;
    req_vld = v;
    req_lvl = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds the given inputs until ack; checks latency and the settled level.
  task automatic run_to_ack(input string name, input logic v, input logic [1:0] l,
                            input int exp_lat, input logic [1:0] exp_cur);
    int n;
    n = 0;
    do begin
      step(1'b0, v, l);
      n++;
      if (!ack) chk({name, ".busy"}, 8'(busy), 8'd1);
    end while (!ack && n < 40);
    if (!ack) begin
      chk({name, ".timeout"}, 8'd0, 8'd1);
    end else begin
      chk({name, ".lat"}, 8'(n), 8'(exp_lat));
      chk({name, ".cur"}, 8'(cur_lvl), 8'(exp_cur));
      chk({name, ".rdy"}, 8'(req_rdy), 8'd0);
      chk({name, ".busy_end"}, 8'(busy), 8'd0);
    end
  endtask

  // Gate ordering invariant and ack bookkeeping every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (sw1 === 1'b1 && sw0 !== 1'b1) begin
        failures++;
        $display("FAIL sw_order: sw1=%0d sw0=%0d required sw0=1", sw1, sw0);
      end
    end
    if (ack === 1'b1) ack_cnt++;
  end

  initial begin
    rst     = 1'b1;
    req_vld = 1'b0;
    req_lvl = 2'd0;

    //   rst vld lvl  rdy ack busy cur sw0 sw1  n
    add(1, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0,   1, 0, 0, 0, 0, 0, 2);
    // 0 -> 1
    add(0, 1, 1,   0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0,   0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 0,   0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 0,   0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0,   1, 0, 0, 1, 1, 0, 1);
    // 1 -> 0
    add(0, 1, 0,   0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0,   0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    // 0 -> 2 requested as level 3
    add(0, 1, 3,   0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0,   0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 0,   0, 0, 1, 0, 1, 1, 4);
    add(0, 0, 0,   0, 1, 0, 2, 1, 1, 1);
    add(0, 0, 0,   0, 0, 0, 2, 1, 1, 1);
    add(0, 0, 0,   1, 0, 0, 2, 1, 1, 1);
    // 2 -> 0
    add(0, 1, 0,   0, 0, 1, 2, 1, 0, 1);
    add(0, 0, 0,   0, 0, 1, 2, 1, 0, 3);
    add(0, 0, 0,   0, 0, 1, 2, 0, 0, 4);
    add(0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0,   1, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].ack) exp_acks++;
      step(vecs[i].rst, vecs[i].vld, vecs[i].lvl);
      chk($sformatf("v%0d.rdy", i),  8'(req_rdy), 8'(vecs[i].rdy));
      chk($sformatf("v%0d.ack", i),  8'(ack),     8'(vecs[i].ack));
      chk($sformatf("v%0d.busy", i), 8'(busy),    8'(vecs[i].busy));
      chk($sformatf("v%0d.cur", i),  8'(cur_lvl), 8'(vecs[i].cur));
      chk($sformatf("v%0d.sw0", i),  8'(sw0),     8'(vecs[i].sw0));
      chk($sformatf("v%0d.sw1", i),  8'(sw1),     8'(vecs[i].sw1));
    end

    // 0 -> 1 with the request held through the transition.
    step(1'b0, 1'b1, 2'd1);
    exp_acks++;
    chk("h01.busy", 8'(busy), 8'd1);
    chk("h01.sw0", 8'(sw0), 8'd1);
    chk("h01.sw1", 8'(sw1), 8'd0);
    run_to_ack("h01", 1'b1, 2'd1, SETTLE, 2'd1);

    // Request presented right after ack waits out the dwell.
    step(1'b0, 1'b1, 2'd2);
    chk("dwell1.rdy", 8'(req_rdy), 8'd0);
    chk("dwell1.busy", 8'(busy), 8'd0);
    chk("dwell1.sw1", 8'(sw1), 8'd0);
    step(1'b0, 1'b1, 2'd2);
    chk("dwell2.rdy", 8'(req_rdy), 8'd1);
    chk("dwell2.busy", 8'(busy), 8'd0);
    step(1'b0, 1'b1, 2'd2);
    exp_acks++;
    chk("h12.busy", 8'(busy), 8'd1);
    chk("h12.sw1", 8'(sw1), 8'd1);

    // New request held while busy is taken only once ready.
    run_to_ack("h12", 1'b1, 2'd1, SETTLE, 2'd2);
    step(1'b0, 1'b1, 2'd1);
    chk("hold1.rdy", 8'(req_rdy), 8'd0);
    chk("hold1.sw1", 8'(sw1), 8'd1);
    step(1'b0, 1'b1, 2'd1);
    chk("hold2.rdy", 8'(req_rdy), 8'd1);
    chk("hold2.busy", 8'(busy), 8'd0);
    step(1'b0, 1'b1, 2'd1);
    exp_acks++;
    chk("h21.busy", 8'(busy), 8'd1);
    chk("h21.sw1", 8'(sw1), 8'd0);
    chk("h21.sw0", 8'(sw0), 8'd1);
    run_to_ack("h21", 1'b0, 2'd0, SETTLE, 2'd1);

    // Same-level request in L1.
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    chk("same.rdy_pre", 8'(req_rdy), 8'd1);
    step(1'b0, 1'b1, 2'd1);
    exp_acks++;
    chk("same.ack", 8'(ack), 8'd1);
    chk("same.busy", 8'(busy), 8'd0);
    chk("same.cur", 8'(cur_lvl), 8'd1);
    chk("same.sw0", 8'(sw0), 8'd1);
    chk("same.sw1", 8'(sw1), 8'd0);
    chk("same.rdy", 8'(req_rdy), 8'd1);
    step(1'b0, 1'b0, 2'd0);
    chk("same.ack_drop", 8'(ack), 8'd0);

    // Reset in the second cycle of UP1.
    step(1'b0, 1'b1, 2'd2);
    chk("rst.up1_a", 8'(busy), 8'd1);
    step(1'b0, 1'b0, 2'd0);
    chk("rst.up1_sw0", 8'(sw0), 8'd1);
    chk("rst.up1_sw1", 8'(sw1), 8'd1);
    step(1'b1, 1'b0, 2'd0);
    chk("rst.sw0", 8'(sw0), 8'd0);
    chk("rst.sw1", 8'(sw1), 8'd0);
    chk("rst.cur", 8'(cur_lvl), 8'd0);
    chk("rst.busy", 8'(busy), 8'd0);
    chk("rst.ack", 8'(ack), 8'd0);
    step(1'b0, 1'b0, 2'd0);
    chk("rst.rdy", 8'(req_rdy), 8'd1);
    chk("rst.ack_after", 8'(ack), 8'd0);

    chk("ack_count", 8'(ack_cnt), 8'(exp_acks));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
